// File: rtl/wb_stopwatch_slave_if.sv
// Wishbone classic bus bundle for the stopwatch slave.
// Master drives the request side; slave returns data and ack.
interface wb_stopwatch_slave_if;
    logic [31:0] wb_addr;
    logic [31:0] wb_data;
    logic [3:0]  wb_sel;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [31:0] wb_data_read;
    logic        wb_ack;

    modport master (
        output wb_addr, wb_data, wb_sel,
        output wb_cyc, wb_stb, wb_we,
        input  wb_data_read, wb_ack
    );

    modport slave (
        input  wb_addr, wb_data, wb_sel,
        input  wb_cyc, wb_stb, wb_we,
        output wb_data_read, wb_ack
    );
endinterface

// File: rtl/wb_stopwatch_slave.sv
// MM:SS BCD stopwatch behind a Wishbone classic slave port.
// Registers: CTRL (run/clear), TIME, STATUS (running/wrap), ID.
module wb_stopwatch_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned TICK_DIV  = 50_000_000
) (
    input  logic                       clk,
    input  logic                       rst,
    wb_stopwatch_slave_if.slave        bus,
    output logic [3:0]                 sec1,
    output logic [3:0]                 sec2,
    output logic [3:0]                 min1,
    output logic [3:0]                 min2,
    output logic                       running
);
    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_TOP = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRE_ONE = PW'(1);
    localparam logic [31:0] ID_VAL = 32'h5357_0001;

    logic          r_ack;
    logic [31:0]   r_rdata;
    logic          r_run;
    logic          r_wrap;
    logic [PW-1:0] r_pre;
    logic [3:0]    r_s1, r_s2, r_m1, r_m2;

    logic          w_match, w_req, w_wr, w_rd;
    logic [1:0]    w_reg;
    logic          w_ctrl_wr, w_clear, w_time_wr, w_w1c;
    logic          w_tick, w_at_max, w_wrap;
    logic [31:0]   w_rmux;
    logic          w_unused;

    function automatic logic [3:0] clamp(input logic [3:0] d,
                                         input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    assign w_match   = bus.wb_addr[31:4] == BASE_ADDR[31:4];
    assign w_req     = bus.wb_cyc & bus.wb_stb & w_match & ~r_ack;
    assign w_wr      = w_req & bus.wb_we;
    assign w_rd      = w_req & ~bus.wb_we;
    assign w_reg     = bus.wb_addr[3:2];
    assign w_ctrl_wr = w_wr & (w_reg == 2'd0) & bus.wb_sel[0];
    assign w_clear   = w_ctrl_wr & bus.wb_data[1];
    assign w_time_wr = w_wr & (w_reg == 2'd1) & ~r_run;
    assign w_w1c     = w_wr & (w_reg == 2'd2) & bus.wb_sel[0]
                     & bus.wb_data[1];
    assign w_tick    = r_run & (r_pre == PRE_TOP);
    assign w_at_max  = (r_m2 == 4'd5) & (r_m1 == 4'd9)
                     & (r_s2 == 4'd5) & (r_s1 == 4'd9);
    // A clear on the tick edge suppresses the increment, hence the wrap too.
    assign w_wrap    = w_tick & w_at_max & ~w_clear;

    assign w_unused  = &{1'b0, bus.wb_addr[1:0], bus.wb_data[31:16],
                         bus.wb_sel[3:2]};

    // Register read multiplexer, sampled into r_rdata on a read request.
    always_comb begin
        w_rmux = '0;
        unique case (w_reg)
            2'd0:    w_rmux = {31'd0, r_run};
            2'd1:    w_rmux = {16'd0, r_m2, r_m1, r_s2, r_s1};
            2'd2:    w_rmux = {30'd0, r_wrap, r_run};
            default: w_rmux = ID_VAL;
        endcase
    end

    // Single-cycle ack and read data; ack blocks a back-to-back request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack   <= w_req;
            r_rdata <= w_rd ? w_rmux : '0;
        end
    end

    // Run bit and sticky wrap flag; a new wrap wins over a W1C.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run  <= 1'b0;
            r_wrap <= 1'b0;
        end else begin
            if (w_ctrl_wr)
                r_run <= bus.wb_data[0];
            if (w_wrap)
                r_wrap <= 1'b1;
            else if (w_w1c)
                r_wrap <= 1'b0;
        end
    end

    // One-second prescaler; holds its value while paused.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_pre <= '0;
        else if (w_clear)
            r_pre <= '0;
        else if (r_run)
            r_pre <= w_tick ? '0 : r_pre + PRE_ONE;
    end

    // BCD time digits: clear, host load while stopped, or ripple on tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 4'd0;
            r_s2 <= 4'd0;
            r_m1 <= 4'd0;
            r_m2 <= 4'd0;
        end else if (w_clear) begin
            r_s1 <= 4'd0;
            r_s2 <= 4'd0;
            r_m1 <= 4'd0;
            r_m2 <= 4'd0;
        end else if (w_time_wr) begin
            if (bus.wb_sel[0]) begin
                r_s1 <= clamp(bus.wb_data[3:0], 4'd9);
                r_s2 <= clamp(bus.wb_data[7:4], 4'd5);
            end
            if (bus.wb_sel[1]) begin
                r_m1 <= clamp(bus.wb_data[11:8], 4'd9);
                r_m2 <= clamp(bus.wb_data[15:12], 4'd5);
            end
        end else if (w_tick) begin
            if (r_s1 != 4'd9) begin
                r_s1 <= r_s1 + 4'd1;
            end else begin
                r_s1 <= 4'd0;
                if (r_s2 != 4'd5) begin
                    r_s2 <= r_s2 + 4'd1;
                end else begin
                    r_s2 <= 4'd0;
                    if (r_m1 != 4'd9) begin
                        r_m1 <= r_m1 + 4'd1;
                    end else begin
                        r_m1 <= 4'd0;
                        r_m2 <= (r_m2 == 4'd5) ? 4'd0 : r_m2 + 4'd1;
                    end
                end
            end
        end
    end

    assign bus.wb_ack       = r_ack;
    assign bus.wb_data_read = r_rdata;
    assign sec1             = r_s1;
    assign sec2             = r_s2;
    assign min1             = r_m1;
    assign min2             = r_m2;
    assign running          = r_run;
endmodule

// File: tb/tb_wb_stopwatch_slave.sv
// Bench for wb_stopwatch_slave: register table, directed timing
// sequences and random bus traffic against a seconds-count model.
module tb_wb_stopwatch_slave;
    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam int TDIV = 4;
    localparam logic [31:0] A_CTRL = BASE + 32'h0;
    localparam logic [31:0] A_TIME = BASE + 32'h4;
    localparam logic [31:0] A_STAT = BASE + 32'h8;
    localparam logic [31:0] A_ID   = BASE + 32'hC;

    logic clk = 1'b0;
    logic rst;
    logic [3:0] sec1, sec2, min1, min2;
    logic running;

    wb_stopwatch_slave_if bus();

    wb_stopwatch_slave #(.BASE_ADDR(BASE), .TICK_DIV(TDIV)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .sec1(sec1), .sec2(sec2), .min1(min1), .min2(min2),
        .running(running)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: elapsed seconds 0..3599 plus prescaler phase.
    int m_sec, m_pre;
    bit m_run, m_wrap, m_ack;
    logic [31:0] m_rd;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lim(input int v, input int l);
        return (v > l) ? l : v;
    endfunction

    function automatic logic [15:0] m_time();
        int s, m;
        s = m_sec % 60;
        m = m_sec / 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic model_step();
        bit req, wr, setw, nrun, nwrap;
        int nsec, npre, ss, mm;
        logic [1:0] off;
        logic [31:0] nrd, d;
        if (rst) begin
            m_sec = 0; m_pre = 0; m_run = 0; m_wrap = 0;
            m_ack = 0; m_rd = 0;
            return;
        end
        req = bus.wb_cyc && bus.wb_stb && !m_ack
            && (bus.wb_addr[31:4] == BASE[31:4]);
        wr  = req && bus.wb_we;
        off = bus.wb_addr[3:2];
        d   = bus.wb_data;
        nrd = 32'h0;
        if (req && !bus.wb_we) begin
            case (off)
                2'd0: nrd = {31'd0, m_run};
                2'd1: nrd = {16'd0, m_time()};
                2'd2: nrd = {30'd0, m_wrap, m_run};
                default: nrd = 32'h5357_0001;
            endcase
        end
        nsec = m_sec; npre = m_pre; nrun = m_run; nwrap = m_wrap; setw = 0;
        if (m_run) begin
            if (m_pre == TDIV - 1) begin
                npre = 0;
                nsec = (m_sec + 1) % 3600;
                setw = (m_sec == 3599);
            end else begin
                npre = m_pre + 1;
            end
        end
        if (wr && off == 2'd0 && bus.wb_sel[0]) begin
            nrun = d[0];
            if (d[1]) begin
                nsec = 0; npre = 0; setw = 0;
            end
        end
        if (wr && off == 2'd1 && !m_run) begin
            ss = m_sec % 60;
            mm = m_sec / 60;
            if (bus.wb_sel[0])
                ss = 10 * lim(int'(d[7:4]), 5) + lim(int'(d[3:0]), 9);
            if (bus.wb_sel[1])
                mm = 10 * lim(int'(d[15:12]), 5) + lim(int'(d[11:8]), 9);
            nsec = mm * 60 + ss;
        end
        if (wr && off == 2'd2 && bus.wb_sel[0] && d[1])
            nwrap = 0;
        if (setw)
            nwrap = 1;
        m_sec = nsec; m_pre = npre; m_run = nrun; m_wrap = nwrap;
        m_ack = req; m_rd = nrd;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        chk("ack", 32'(bus.wb_ack), 32'(m_ack));
        chk("rdata", bus.wb_data_read, m_rd);
        chk("digits", 32'({min2, min1, sec2, sec1}), 32'(m_time()));
        chk("running", 32'(running), 32'(m_run));
    endtask

    task automatic idle(input int n);
        bus.wb_cyc = 0; bus.wb_stb = 0; bus.wb_we = 0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wb_wr(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        bus.wb_addr = a; bus.wb_data = d; bus.wb_sel = s;
        bus.wb_we = 1; bus.wb_cyc = 1; bus.wb_stb = 1;
        step();
        bus.wb_cyc = 0; bus.wb_stb = 0; bus.wb_we = 0;
        step();
    endtask

    task automatic wb_rd(input logic [31:0] a, output logic [31:0] d);
        bus.wb_addr = a; bus.wb_sel = 4'hF;
        bus.wb_we = 0; bus.wb_cyc = 1; bus.wb_stb = 1;
        step();
        d = bus.wb_data_read;
        bus.wb_cyc = 0; bus.wb_stb = 0;
        step();
    endtask

    function automatic logic [31:0] dig();
        return 32'({min2, min1, sec2, sec1});
    endfunction

    initial begin
        logic [31:0] rd;
        tbl[0]  = '{1'b1, A_TIME, 32'h0000_7A9C, 4'h3, 32'h0};
        tbl[1]  = '{1'b0, A_TIME, 32'h0, 4'hF, 32'h0000_5959};
        tbl[2]  = '{1'b1, A_TIME, 32'h0000_1234, 4'h1, 32'h0};
        tbl[3]  = '{1'b0, A_TIME, 32'h0, 4'hF, 32'h0000_5934};
        tbl[4]  = '{1'b1, A_TIME, 32'h0000_0812, 4'h2, 32'h0};
        tbl[5]  = '{1'b0, A_TIME, 32'h0, 4'hF, 32'h0000_0834};
        tbl[6]  = '{1'b1, A_TIME, 32'h0000_FFFF, 4'h0, 32'h0};
        tbl[7]  = '{1'b0, A_TIME, 32'h0, 4'hF, 32'h0000_0834};
        tbl[8]  = '{1'b1, A_CTRL, 32'h0000_0003, 4'hE, 32'h0};
        tbl[9]  = '{1'b0, A_CTRL, 32'h0, 4'hF, 32'h0};
        tbl[10] = '{1'b0, A_ID,   32'h0, 4'hF, 32'h5357_0001};
        tbl[11] = '{1'b1, A_ID,   32'h0, 4'hF, 32'h0};
        tbl[12] = '{1'b0, A_ID,   32'h0, 4'hF, 32'h5357_0001};
        tbl[13] = '{1'b1, A_STAT, 32'h2, 4'h1, 32'h0};
        tbl[14] = '{1'b0, A_STAT, 32'h0, 4'hF, 32'h0};

        rst = 1;
        bus.wb_addr = 0; bus.wb_data = 0; bus.wb_sel = 0;
        bus.wb_cyc = 0; bus.wb_stb = 0; bus.wb_we = 0;
        m_sec = 0; m_pre = 0; m_run = 0; m_wrap = 0; m_ack = 0; m_rd = 0;
        step();
        step();
        rst = 0;
        chk("reset_ack", 32'(bus.wb_ack), 32'h0);
        chk("reset_rdata", bus.wb_data_read, 32'h0);
        chk("reset_digits", dig(), 32'h0);
        chk("reset_running", 32'(running), 32'h0);
        idle(2);

        // Register access table, stopwatch stopped.
        for (int i = 0; i < 15; i++) begin
            if (tbl[i].we) begin
                wb_wr(tbl[i].addr, tbl[i].data, tbl[i].sel);
            end else begin
                wb_rd(tbl[i].addr, rd);
                chk($sformatf("tbl%0d", i), rd, tbl[i].exp);
            end
        end

        // ID read with strobe held: ack pulses, then drops.
        bus.wb_addr = A_ID; bus.wb_we = 0; bus.wb_cyc = 1; bus.wb_stb = 1;
        step();
        chk("id_ack", 32'(bus.wb_ack), 32'h1);
        chk("id_data", bus.wb_data_read, 32'h5357_0001);
        step();
        chk("id_ack_low", 32'(bus.wb_ack), 32'h0);
        chk("id_data_low", bus.wb_data_read, 32'h0);
        step();
        chk("id_ack_again", 32'(bus.wb_ack), 32'h1);
        idle(1);

        // 59:58 plus two ticks wraps to 00:00 and sets wrap.
        wb_wr(A_TIME, 32'h0000_5958, 4'hF);
        wb_wr(A_CTRL, 32'h1, 4'h1);
        idle(7);
        chk("wrap_digits", dig(), 32'h0);
        wb_rd(A_STAT, rd);
        chk("wrap_status", rd, 32'h3);
        wb_wr(A_STAT, 32'h2, 4'h1);
        wb_rd(A_STAT, rd);
        chk("w1c_status", rd, 32'h1);

        // Pause keeps prescaler phase; resume ticks two cycles later.
        wb_wr(A_CTRL, 32'h3, 4'h1);
        wb_wr(A_CTRL, 32'h0, 4'h1);
        idle(20);
        chk("pause_digits", dig(), 32'h0);
        wb_wr(A_CTRL, 32'h1, 4'h1);
        chk("resume_pre_tick", dig(), 32'h0);
        idle(1);
        chk("resume_tick", dig(), 32'h1);

        // Clear+run lands on a tick edge: clear wins, phase restarts.
        idle(3);
        wb_wr(A_CTRL, 32'h3, 4'h1);
        chk("clr_tick_digits", dig(), 32'h0);
        chk("clr_tick_running", 32'(running), 32'h1);
        idle(2);
        chk("clr_phase_a", dig(), 32'h0);
        idle(1);
        chk("clr_phase_b", dig(), 32'h1);

        // TIME writes are ignored while running.
        wb_wr(A_TIME, 32'h0000_7A9C, 4'h3);
        chk("time_wr_running", dig(), 32'h1);

        // Wrap set and W1C on the same edge: set wins.
        wb_wr(A_CTRL, 32'h2, 4'h1);
        wb_wr(A_TIME, 32'h0000_5959, 4'h3);
        wb_wr(A_CTRL, 32'h1, 4'h1);
        idle(2);
        wb_wr(A_STAT, 32'h2, 4'h1);
        chk("setwin_digits", dig(), 32'h0);
        wb_rd(A_STAT, rd);
        chk("setwin_status", rd, 32'h3);
        wb_wr(A_CTRL, 32'h2, 4'h1);

        // Out-of-range address never acks.
        bus.wb_addr = BASE + 32'h10; bus.wb_we = 0;
        bus.wb_cyc = 1; bus.wb_stb = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("nomatch_ack", 32'(bus.wb_ack), 32'h0);
        end
        idle(1);

        // Reset in the middle of an ack cycle.
        wb_wr(A_TIME, 32'h0000_1234, 4'h3);
        wb_wr(A_CTRL, 32'h1, 4'h1);
        bus.wb_addr = A_ID; bus.wb_we = 0; bus.wb_cyc = 1; bus.wb_stb = 1;
        step();
        chk("pre_rst_ack", 32'(bus.wb_ack), 32'h1);
        #2 rst = 1;
        #1;
        chk("rst_ack", 32'(bus.wb_ack), 32'h0);
        chk("rst_rdata", bus.wb_data_read, 32'h0);
        chk("rst_digits", dig(), 32'h0);
        chk("rst_running", 32'(running), 32'h0);
        bus.wb_addr = A_TIME; bus.wb_data = 32'h4321;
        bus.wb_sel = 4'h3; bus.wb_we = 1;
        step();
        step();
        bus.wb_cyc = 0; bus.wb_stb = 0; bus.wb_we = 0;
        rst = 0;
        step();
        wb_rd(A_TIME, rd);
        chk("rst_no_commit", rd, 32'h0);

        // Random traffic against the model, crossing a wrap.
        wb_wr(A_TIME, 32'h0000_5945, 4'h3);
        wb_wr(A_CTRL, 32'h1, 4'h1);
        for (int i = 0; i < 400; i++) begin
            logic [1:0] off;
            logic [31:0] d;
            off = 2'($urandom_range(0, 3));
            d = $urandom;
            if (off == 2'd0) begin
                d[0] = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 7) != 0) d[1] = 1'b0;
            end
            bus.wb_cyc = ($urandom_range(0, 9) < 7);
            bus.wb_stb = ($urandom_range(0, 3) != 0);
            bus.wb_we = 1'($urandom_range(0, 1));
            bus.wb_sel = 4'($urandom);
            bus.wb_data = d;
            if ($urandom_range(0, 9) == 0)
                bus.wb_addr = BASE + 32'h10 + {28'd0, off, 2'b00};
            else
                bus.wb_addr = BASE + {28'd0, off, 2'b00};
            step();
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
